// File: rtl/regfile_pkg.sv
// regfile_pkg: default sizes and register index type shared by the regfile_sb slice
package regfile_pkg;
  localparam int XLEN_DEF = 64;
  localparam int NREG_DEF = 32;
  localparam int NRD_DEF = 2;
  localparam int NWR_DEF = 2;
  typedef logic [$clog2(NREG_DEF)-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_sb_busy.sv
// regfile_sb_busy: pending-producer scoreboard
//   in: clk, reset, wr_en/wr_addr (clears), iss_en/iss_addr (set), flush (clear all)
//   out: busy_vec registered pending bits, bit 0 held at 0
module regfile_sb_busy import regfile_pkg::*; #(
  parameter int NREG = NREG_DEF,
  parameter int NWR = NWR_DEF,
  parameter int AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  input  logic              flush,
  output logic [NREG-1:0]   busy_vec
);
  logic [NREG-1:0] busy_d;
  // flush beats issue beats write-clear; an issue is a newer producer than any completing write
  always_comb begin
    busy_d = busy_vec;
    for (int w = 0; w < NWR; w++)
      if (wr_en[w]) busy_d[wr_addr[w*AW +: AW]] = 1'b0;
    if (iss_en) busy_d[iss_addr] = 1'b1;
    if (flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) busy_vec <= '0;
    else busy_vec <= busy_d;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-ported register file with write-to-read bypass and busy scoreboard
//   in: clk, reset, rd_addr, wr_en/wr_addr/wr_data, iss_en/iss_addr, flush
//   out: rd_data, rd_ready per read port; busy_vec pending bits
module regfile_sb import regfile_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD = NRD_DEF,
  parameter int NWR = NWR_DEF,
  parameter int AW = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_ready,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic                flush,
  output logic [NREG-1:0]     busy_vec
);
  logic [XLEN-1:0] regs [NREG];
  regfile_sb_busy #(.NREG(NREG), .NWR(NWR), .AW(AW)) u_busy (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy_vec(busy_vec)
  );
  // later ports overwrite earlier ones in the loop, so the highest index wins
  always_ff @(posedge clk or posedge reset)
    if (reset) for (int i = 0; i < NREG; i++) regs[i] <= '0;
    else
      for (int w = 0; w < NWR; w++)
        if (wr_en[w] && wr_addr[w*AW +: AW] != '0) regs[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] a;
    logic hit;
    logic [XLEN-1:0] d;
    assign a = rd_addr[p*AW +: AW];
    always_comb begin
      hit = 1'b0;
      d = regs[a];
      for (int w = 0; w < NWR; w++)
        if (wr_en[w] && wr_addr[w*AW +: AW] == a) begin
          hit = 1'b1;
          d = wr_data[w*XLEN +: XLEN];
        end
    end
    // reset also masks the bypass path so in-flight write data never shows while reset is high
    assign rd_data[p*XLEN +: XLEN] = (reset || a == '0) ? '0 : d;
    assign rd_ready[p] = reset || a == '0 || hit || !busy_vec[a];
  end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameters SHALL be, as name, default, meaning: XLEN, 64, data width; NREG, 32, register count (power of 2, >=2); NRD, 2, read ports; NWR, 2, write ports; AW, $clog2(NREG), address width (derived).
REQ-002 clk  input  1  clock; all state SHALL update on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rd_addr  input  NRD*AW  read addresses; port p uses bits [p*AW +: AW].
REQ-005 rd_data  output  NRD*XLEN  read data per port.
REQ-006 rd_ready  output  NRD  per-port operand-ready flag.
REQ-007 wr_en  input  NWR  per-port write enable.
REQ-008 wr_addr  input  NWR*AW  write addresses.
REQ-009 wr_data  input  NWR*XLEN  write data.
REQ-010 iss_en  input  1  issue strobe: mark iss_addr pending.
REQ-011 iss_addr  input  AW  destination register being issued.
REQ-012 flush  input  1  clear all pending bits.
REQ-013 busy_vec  output  NREG  registered pending bits; bit 0 SHALL always read 0.

Function
REQ-014 Register 0 SHALL read as zero with rd_ready=1; writes and issues to address 0 SHALL be ignored.
REQ-015 Write on port w SHALL update regs[wr_addr[w]] at the clock edge where wr_en[w]=1; write latency is one cycle to registered state.
REQ-016 Same-cycle writes to one address from several ports: highest-index port SHALL win.
REQ-017 Reads SHALL be combinational with write-to-read bypass: if any enabled write targets rd_addr[p] (nonzero) this cycle, rd_data[p] SHALL be that write's data (REQ-016 priority); otherwise the stored value.
REQ-018 rd_ready[p] SHALL be 1 when busy_q[rd_addr[p]]=0 or an enabled write targets rd_addr[p] this cycle; same-cycle iss_en SHALL NOT affect rd_ready.
REQ-019 Any enabled write to address a SHALL clear busy_q[a] next cycle.
REQ-020 iss_en to address a SHALL set busy_q[a] next cycle; simultaneous write and issue to a: set SHALL win (newer producer).
REQ-021 flush SHALL clear all busy bits next cycle, overriding iss_en in the same cycle; writes in a flush cycle SHALL still update data.
REQ-022 Read addresses, write addresses and iss_addr SHALL be fully decoded over NREG entries; no out-of-range aliasing exists since NREG=2^AW.

Reset
REQ-023 While reset=1, all NREG data registers SHALL be 0, all busy bits 0, rd_ready all 1, rd_data all 0.
REQ-024 Reset asserted mid-operation SHALL discard pending writes and issues of that cycle; first write SHALL be accepted on the first rising edge after deassertion.

Structure
REQ-025 A shared package regfile_pkg SHALL hold default XLEN, NREG, NRD, NWR constants and the register index typedef.
REQ-026 Scoreboard SHALL be one sub-module, regfile_sb_busy (busy bits with set/clear/flush priority); data array and bypass muxes reside in regfile_sb.

Verification
REQ-027 Reset, then read all 32 addresses on both ports -> rd_data=0, rd_ready=1 for all.
REQ-028 wr_en=01, wr_addr[0]=5, data 0xDEADBEEF_00000001; same cycle rd_addr[0]=5 -> rd_data[0]=0xDEADBEEF_00000001 (bypass); next cycle, no write -> same value.
REQ-029 wr_en=11, both ports addr 7, data A=0x1, B=0x2 -> reg 7 reads 0x2.
REQ-030 iss_en addr 9; next cycle read 9 -> rd_ready=0; write 9 = 0x55 that cycle -> rd_ready=1, data 0x55; following cycle busy_vec[9]=0.
REQ-031 Same cycle write 3 and iss_en 3 -> busy_vec[3]=1 next cycle; then flush with iss_en 4 -> busy_vec all 0.
REQ-032 Write x0 = 0xFFFF, iss_en x0 -> rd_data=0, rd_ready=1, busy_vec[0]=0; assert reset mid-write to reg 12 -> reg 12 reads 0.
